// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// immediate formats, ALU operations and datapath mux selects.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL, S_LUI
  } state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE: return IMM_S;
      OP_BR:    return IMM_B;
      OP_JAL:   return IMM_J;
      OP_LUI:   return IMM_U;
      default:  return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps the controller's alu_op class plus funct fields
// to a concrete ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback through the shared ALU and memory port.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       illegal_instr
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;
  logic       taken;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_ctl)
  );

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    result_src    = RES_ALUOUT;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BR:             state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALRADR;
          OP_LUI:            state_next = S_LUI;
          default: begin
            illegal_instr = 1'b1;
            state_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write   = taken;
        state_next = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = S_JAL;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
    // Reset overrides everything so an in-flight memory access is dropped immediately.
    if (rst) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = '0;
      alu_src_b     = '0;
      result_src    = '0;
      illegal_instr = 1'b0;
    end
  end

  assign imm_src     = rst ? '0 : imm_sel(op);
  assign alu_control = rst ? '0 : alu_ctl;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words
// are queued by the stimulus process and checked by an independent monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [2:0] imm_src, alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .result_src(result_src),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   stim_done = 1'b0;

  // word layout: mem_req mem_write adr_src ir_write pc_write reg_write imm a b alu res illegal
  function automatic logic [18:0] ev(input logic mreq, mw, adr, irw, pcw, rw,
                                     input logic [2:0] im, input logic [1:0] a, b,
                                     input logic [2:0] alu, input logic [1:0] res,
                                     input logic ill);
    return {mreq, mw, adr, irw, pcw, rw, im, a, b, alu, res, ill};
  endfunction

  task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic n, input logic rdy);
    rst = r; op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n; mem_ready = rdy;
  endtask

  task automatic step(input logic [18:0] e, input string nm);
    exp_t x;
    x.v = e;
    x.nm = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic [2:0] im, input string nm);
    drive(0, o, f3, f7, 0, 0, 1);
    step(ev(1,0,0,1,1,0, im, 2'b00, 2'b10, 3'b000, 2'b10, 0), {nm, "_fetch"});
    step(ev(0,0,0,0,0,0, im, 2'b01, 2'b01, 3'b000, 2'b00, 0), {nm, "_decode"});
  endtask

  task automatic aluwb(input logic [2:0] im, input string nm);
    step(ev(0,0,0,0,0,1, im, 2'b00, 2'b00, 3'b000, 2'b00, 0), {nm, "_aluwb"});
  endtask

  task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] alu,
                       input string nm);
    fetch_decode(7'b0110011, f3, f7, 3'b000, nm);
    step(ev(0,0,0,0,0,0, 3'b000, 2'b10, 2'b00, alu, 2'b00, 0), {nm, "_execr"});
    aluwb(3'b000, nm);
  endtask

  task automatic itype(input logic [2:0] f3, input logic f7, input logic [2:0] alu,
                       input string nm);
    fetch_decode(7'b0010011, f3, f7, 3'b000, nm);
    step(ev(0,0,0,0,0,0, 3'b000, 2'b10, 2'b01, alu, 2'b00, 0), {nm, "_execi"});
    aluwb(3'b000, nm);
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic n,
                        input logic tk, input string nm);
    fetch_decode(7'b1100011, f3, 0, 3'b010, nm);
    drive(0, 7'b1100011, f3, 0, z, n, 1);
    step(ev(0,0,0,0,tk,0, 3'b010, 2'b10, 2'b00, 3'b001, 2'b00, 0), {nm, "_branch"});
    drive(0, 7'b1100011, f3, 0, 0, 0, 1);
  endtask

  // Monitor: compares the DUT control word once per cycle, away from the active edge.
  initial begin : monitor
    exp_t x;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_src,
               alu_src_a, alu_src_b, alu_control, result_src, illegal_instr};
        tests++;
        if (act !== x.v) begin
          fails++;
          $display("FAIL %s: got %b required %b", x.nm, act, x.v);
        end
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    drive(1, 7'b0110011, 3'b000, 0, 1, 1, 1);
    step('0, "reset0");
    step('0, "reset1");

    rtype(3'b000, 0, 3'b000, "add");
    rtype(3'b000, 1, 3'b001, "sub");
    rtype(3'b010, 0, 3'b101, "slt");
    rtype(3'b110, 0, 3'b011, "or");
    rtype(3'b111, 0, 3'b010, "and");
    itype(3'b100, 0, 3'b100, "xori");
    itype(3'b000, 1, 3'b000, "addi_f7b5");

    // lw with three wait states in MEMREAD: 8 cycles in total
    fetch_decode(7'b0000011, 3'b010, 0, 3'b000, "lw");
    step(ev(0,0,0,0,0,0, 3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 0), "lw_memadr");
    drive(0, 7'b0000011, 3'b010, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++)
      step(ev(1,0,1,0,0,0, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0), "lw_memread_stall");
    drive(0, 7'b0000011, 3'b010, 0, 0, 0, 1);
    step(ev(1,0,1,0,0,0, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00, 0), "lw_memread");
    step(ev(0,0,0,0,0,1, 3'b000, 2'b00, 2'b00, 3'b000, 2'b01, 0), "lw_memwb");

    branch(3'b000, 1, 0, 1, "beq_taken");
    branch(3'b000, 0, 0, 0, "beq_not");
    branch(3'b101, 0, 1, 0, "bge_not");
    branch(3'b100, 0, 1, 1, "blt_taken");
    branch(3'b011, 1, 1, 0, "bra_f3_011");

    fetch_decode(7'b1100111, 3'b000, 0, 3'b000, "jalr");
    step(ev(0,0,0,0,0,0, 3'b000, 2'b10, 2'b01, 3'b000, 2'b00, 0), "jalr_adr");
    step(ev(0,0,0,0,1,0, 3'b000, 2'b01, 2'b10, 3'b000, 2'b00, 0), "jalr_jal");
    aluwb(3'b000, "jalr");

    fetch_decode(7'b1101111, 3'b000, 0, 3'b011, "jal");
    step(ev(0,0,0,0,1,0, 3'b011, 2'b01, 2'b10, 3'b000, 2'b00, 0), "jal_jal");
    aluwb(3'b011, "jal");

    fetch_decode(7'b0110111, 3'b000, 0, 3'b100, "lui");
    step(ev(0,0,0,0,0,0, 3'b100, 2'b11, 2'b01, 3'b000, 2'b00, 0), "lui_lui");
    aluwb(3'b100, "lui");

    drive(0, 7'b1111111, 3'b000, 0, 0, 0, 1);
    step(ev(1,0,0,1,1,0, 3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0), "ill_fetch");
    step(ev(0,0,0,0,0,0, 3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 1), "ill_decode");
    drive(0, 7'b0110011, 3'b000, 0, 0, 0, 1);
    step(ev(1,0,0,1,1,0, 3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 0), "ill_next_fetch");
    step(ev(0,0,0,0,0,0, 3'b000, 2'b01, 2'b01, 3'b000, 2'b00, 0), "ill_next_decode");
    step(ev(0,0,0,0,0,0, 3'b000, 2'b10, 2'b00, 3'b000, 2'b00, 0), "ill_next_execr");
    aluwb(3'b000, "ill_next");

    // sw stalled in MEMWRITE, then reset aborts the access
    fetch_decode(7'b0100011, 3'b010, 0, 3'b001, "sw");
    step(ev(0,0,0,0,0,0, 3'b001, 2'b10, 2'b01, 3'b000, 2'b00, 0), "sw_memadr");
    drive(0, 7'b0100011, 3'b010, 0, 0, 0, 0);
    step(ev(1,1,1,0,0,0, 3'b001, 2'b00, 2'b00, 3'b000, 2'b00, 0), "sw_memwrite_stall");
    drive(1, 7'b0100011, 3'b010, 0, 0, 0, 0);
    step('0, "sw_rst_abort");
    drive(0, 7'b0100011, 3'b010, 0, 0, 0, 1);
    step(ev(1,0,0,1,1,0, 3'b001, 2'b00, 2'b10, 3'b000, 2'b10, 0), "sw_after_rst_fetch");

    repeat (2) @(negedge clk);
    stim_done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (stim_done);
      #20000;
    join_any
    disable fork;
    tests++;
    if (!stim_done || q.size() != 0) begin
      fails++;
      $display("FAIL drain: stim_done=%0d pending=%0d required 1 and 0", stim_done, q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
